uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte-wide transmit buffer with a drain state machine, placed directly upstream of `uart_top`'s transmit side. It accepts single-cycle write strobes from producer logic (echo path, command responder) and queues up to DEPTH bytes. It presents them one at a time to `uart_top` through the `i_tx_dv`/`i_tx_byte` strobe, pacing on `o_tx_active`/`o_tx_done`. Producers can therefore emit bursts without tracking UART occupancy.

## Interface
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥ 2.
- AFULL_LVL, DEPTH-2, `o_almost_full` asserts when count ≥ AFULL_LVL.
- i_clk  in  1  system clock (25 MHz on Colorlight i9).
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_wr_en  in  1  write strobe; byte accepted on any rising edge with i_wr_en=1 and o_full=0.
- i_wr_data  in  8  byte to enqueue.
- o_full  out  1  count == DEPTH.
- o_almost_full  out  1  count ≥ AFULL_LVL.
- o_empty  out  1  count == 0.
- o_count  out  $clog2(DEPTH)+1  bytes stored, not counting the byte currently handed to the UART.
- o_overflow  out  1  one-cycle pulse when a write is dropped.
- o_tx_dv  out  1  to uart_top i_tx_dv; one-cycle start strobe.
- o_tx_byte  out  8  to uart_top i_tx_byte; held stable from strobe until next strobe.
- i_tx_active  in  1  from uart_top o_tx_active.
- i_tx_done  in  1  from uart_top o_tx_done (one-cycle pulse at end of stop bit).
- o_busy  out  1  high when FSM ≠ IDLE or o_empty=0.

## Operation
- Storage: DEPTH×8 register array, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register (0..DEPTH).
- Write: if i_wr_en && !o_full, then mem[wr_ptr] <= i_wr_data and wr_ptr++. If i_wr_en && o_full, the byte is discarded, o_overflow pulses, and pointers and count are unchanged.
- A pop and a write in the same cycle leave count unchanged. When full, a write is dropped even if a pop occurs in that cycle. No bypass: an empty FIFO never forwards i_wr_data combinationally.
- FSM states:
  - IDLE: if count ≠ 0, go to LOAD.
  - LOAD: o_tx_dv=1 for exactly this cycle; o_tx_byte <= mem[rd_ptr]; rd_ptr++ and count-- (pop). Next state is WAIT_START.
  - WAIT_START: wait for i_tx_active=1 and then go to WAIT_DONE. If i_tx_done=1 arrives here, go directly to IDLE.
  - WAIT_DONE: wait for i_tx_done=1, then go to IDLE.
- i_tx_done and i_tx_active are ignored in IDLE and LOAD (stale done after reset is harmless).
- o_tx_byte is registered and changes only in LOAD.
- o_full, o_empty, o_almost_full, and o_count are derived from the registered count; they update the cycle after the write or pop edge.

## Timing
- Reset values (async, immediate):
  - FSM: IDLE.
  - Pointers and count: 0.
  - Flags: o_empty=1, o_full=0, o_almost_full=0 (unless AFULL_LVL=0), o_overflow=0.
  - Outputs: o_tx_dv=0, o_tx_byte=8'h00, o_busy=0.
  - Memory contents need not be reset.
- Write-to-strobe latency with FIFO empty and FSM IDLE:
  - Write sampled at edge N.
  - count=1 after N; FSM enters LOAD at edge N+1.
  - o_tx_dv high during cycle N+1..N+2.
  - The strobe is 2 cycles after the write edge.
- Back-to-back: after i_tx_done is sampled in WAIT_DONE at edge M, FSM is IDLE after M. Next LOAD starts at M+1, giving o_tx_dv one cycle wide at M+1..M+2. The inter-byte gap is therefore 2 clocks beyond uart_top's stop bit.
- At most one byte is outstanding at uart_top; o_tx_dv never asserts while the FSM is in WAIT_START or WAIT_DONE.
- Reset asserted mid-transmission: FIFO and FSM clear immediately. uart_top finishes its frame independently, and its later o_tx_done is ignored in IDLE.
- Throughput at 9600 baud: one byte per 2604×10 + 2 clocks.

## Test plan
- Single byte: write 0x41 at edge N -> o_tx_dv pulse of exactly 1 cycle starting after N+1 with o_tx_byte=0x41. Drive i_tx_active 1 cycle later and i_tx_done 20 cycles later -> o_busy=0 one cycle after the done edge.
- Burst order: write 0x01..0x10 on 16 consecutive cycles (DEPTH=16), modelling uart_top with a behavioural responder -> o_tx_byte sequence is 0x01..0x10 with no repeats or gaps. o_full is never asserted because the first pop overlaps; o_overflow stays 0.
- Overflow: hold responder in WAIT_DONE, write 18 bytes 0xA0..0xB1 -> one byte is in flight, 16 are stored, and the last write 0xB1 is dropped with o_overflow pulsing once. o_full=1 and o_almost_full=1 from count 14. The drained sequence is 0xA0..0xB0.
- Simultaneous write/pop at count=3 -> count stays 3 and the written byte is sent after the existing three.
- Wrap-around: 40 bytes streamed through DEPTH=16 with random write gaps -> output matches a reference queue and pointers wrap correctly.
- Reset mid-frame: assert i_rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs take reset values immediately. A subsequent i_tx_done produces no o_tx_dv, and a new write after reset is sent with 2-cycle latency.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with a drain FSM that feeds uart_top one byte at a time
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [7:0]             i_wr_data,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done,
  output logic                   o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;
  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          wr_ok, pop;
  always_comb begin
    wr_ok = i_wr_en && !o_full;
    pop   = state == LOAD;
  end
  assign o_count       = count;
  assign o_full        = count == FULL_CNT;
  assign o_almost_full = count >= AFULL_CNT;
  assign o_empty       = count == '0;
  assign o_busy        = state != IDLE || count != '0;
  always_ff @(posedge i_clk)
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count      <= count + CW'(wr_ok) - CW'(pop);
      o_overflow <= i_wr_en && o_full;
    end
  // The byte is latched on entry to LOAD so it is valid for the whole strobe cycle; the pop retires it on exit.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= IDLE;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        IDLE: if (count != '0) begin
          state     <= LOAD;
          o_tx_dv   <= 1'b1;
          o_tx_byte <= mem[rd_ptr];
        end
        LOAD:       state <= WAIT_START;
        WAIT_START: state <= i_tx_done ? IDLE : (i_tx_active ? WAIT_DONE : WAIT_START);
        WAIT_DONE:  state <= i_tx_done ? IDLE : WAIT_DONE;
        default:    state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table-driven vectors plus hand-written sequences against a behavioural uart_top responder
module tb_uart_tx_fifo;
  logic       clk_50mhz = 1'b0;
  logic       reset_n_internal = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, almost_full, empty, overflow, tx_dv, busy;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       tx_active, tx_done;
  logic       tb_active = 1'b0, tb_done = 1'b0;
  logic       resp_active = 1'b0, resp_done = 1'b0;
  logic       use_resp = 1'b0, resp_hold = 1'b0;
  int         frame_len = 5;
  int         busy_cnt = 0;
  int         n_cmp = 0, n_err = 0;
  int         dv_cnt = 0, ovf_cnt = 0, full_cnt = 0;
  int         got_base, dv_base, ovf_base, full_base;
  logic [7:0] got [$];
  logic [7:0] ref_q [$];

  always #10 clk_50mhz = ~clk_50mhz;
  assign tx_active = use_resp ? resp_active : tb_active;
  assign tx_done   = use_resp ? resp_done : tb_done;

  uart_tx_fifo dut (
    .i_clk(clk_50mhz), .i_rst_n(reset_n_internal), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_almost_full(almost_full), .o_empty(empty), .o_count(count),
    .o_overflow(overflow), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
    .i_tx_active(tx_active), .i_tx_done(tx_done), .o_busy(busy)
  );

  // uart_top stand-in: busy for frame_len cycles after a strobe, done pulse unless held
  always @(negedge clk_50mhz) begin
    resp_done = 1'b0;
    if (!use_resp || !reset_n_internal) begin
      resp_active = 1'b0;
      busy_cnt = 0;
    end else if (tx_dv) begin
      resp_active = 1'b1;
      busy_cnt = frame_len;
    end else if (busy_cnt > 1) busy_cnt--;
    else if (busy_cnt == 1 && !resp_hold) begin
      busy_cnt = 0;
      resp_active = 1'b0;
      resp_done = 1'b1;
    end
  end

  always @(negedge clk_50mhz) begin
    if (tx_dv) begin
      got.push_back(tx_byte);
      dv_cnt++;
    end
    if (overflow) ovf_cnt++;
    if (full) full_cnt++;
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       act, done;
    logic       dv;
    logic [7:0] byt;
    logic [4:0] cnt;
    logic       emp, bsy;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic mark();
    got_base = got.size();
    dv_base = dv_cnt;
    ovf_base = ovf_cnt;
    full_base = full_cnt;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    tb_active = 1'b0;
    tb_done = 1'b0;
    resp_hold = 1'b0;
    reset_n_internal = 1'b0;
    step();
    reset_n_internal = 1'b1;
    step();
    mark();
  endtask

  task automatic wait_drain(input int n);
    int t = 0;
    while ((got.size() - got_base < n || busy) && t < 5000) begin
      step();
      t++;
    end
    chk("drain_timeout", 32'(t >= 5000), 0);
    chk("drain_bytes", got.size() - got_base, n);
  endtask

  task automatic wait_dv();
    int t = 0;
    while (!tx_dv && t < 500) begin
      step();
      t++;
    end
    chk("dv_timeout", 32'(t >= 500), 0);
  endtask

  task automatic write_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = first + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int exp_c, t;
    //            wr  data   act done  dv  byte   cnt emp bsy
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0};

    #5;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].wr;
      wr_data = tbl[i].d;
      tb_active = tbl[i].act;
      tb_done = tbl[i].done;
      step();
      chk($sformatf("vec%0d_dv", i), tx_dv, tbl[i].dv);
      chk($sformatf("vec%0d_byte", i), tx_byte, tbl[i].byt);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].emp);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
    end
    wr_en = 1'b0;
    tb_active = 1'b0;
    tb_done = 1'b0;

    // burst of 16: first pop overlaps so the FIFO never fills
    use_resp = 1'b1;
    frame_len = 5;
    do_reset();
    write_seq(8'h01, 16);
    wait_drain(16);
    for (int i = 0; i < 16 && got_base + i < got.size(); i++)
      chk($sformatf("burst_byte%0d", i), got[got_base + i], 32'(i + 1));
    chk("burst_full_seen", full_cnt - full_base, 0);
    chk("burst_ovf", ovf_cnt - ovf_base, 0);

    // overflow: responder held, 18 writes, last one dropped
    do_reset();
    resp_hold = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      wr_en = 1'b1;
      wr_data = 8'hA0 + 8'(k - 1);
      step();
      exp_c = k <= 2 ? k : (k - 1 > 16 ? 16 : k - 1);
      chk($sformatf("ovf_count_w%0d", k), count, exp_c);
      chk($sformatf("ovf_afull_w%0d", k), almost_full, 32'(exp_c >= 14));
      chk($sformatf("ovf_full_w%0d", k), full, 32'(exp_c == 16));
      chk($sformatf("ovf_pulse_w%0d", k), overflow, 32'(k == 18));
    end
    wr_en = 1'b0;
    step();
    chk("ovf_pulse_end", overflow, 0);
    chk("ovf_count_hold", count, 16);
    resp_hold = 1'b0;
    wait_drain(17);
    for (int i = 0; i < 17 && got_base + i < got.size(); i++)
      chk($sformatf("ovf_byte%0d", i), got[got_base + i], 32'(8'hA0 + i));
    chk("ovf_pulses", ovf_cnt - ovf_base, 1);

    // simultaneous write and pop at count 3
    frame_len = 4;
    do_reset();
    resp_hold = 1'b1;
    write_seq(8'h11, 4);
    step();
    step();
    chk("sim_count_pre", count, 3);
    resp_hold = 1'b0;
    wait_dv();
    resp_hold = 1'b1;
    chk("sim_dv_byte", tx_byte, 8'h12);
    wr_en = 1'b1;
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("sim_count_post", count, 3);
    resp_hold = 1'b0;
    wait_drain(5);
    ref_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h99};
    for (int i = 0; i < 5 && got_base + i < got.size(); i++)
      chk($sformatf("sim_byte%0d", i), got[got_base + i], ref_q[i]);

    // wrap-around: 40 random bytes with random gaps against a reference queue
    frame_len = 3;
    do_reset();
    ref_q.delete();
    t = 0;
    while (ref_q.size() < 40 && t < 4000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        ref_q.push_back(wr_data);
      end
      step();
      wr_en = 1'b0;
      repeat ($urandom_range(0, 6)) step();
      t++;
    end
    wait_drain(40);
    for (int i = 0; i < 40 && got_base + i < got.size(); i++)
      chk($sformatf("wrap_byte%0d", i), got[got_base + i], ref_q[i]);

    // reset during WAIT_DONE with 5 queued
    do_reset();
    resp_hold = 1'b1;
    write_seq(8'hC0, 6);
    step();
    step();
    chk("mrst_count_pre", count, 5);
    tb_active = 1'b1;
    tb_done = 1'b0;
    use_resp = 1'b0;
    #3;
    reset_n_internal = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_dv", tx_dv, 0);
    chk("mrst_byte", tx_byte, 8'h00);
    chk("mrst_afull", almost_full, 0);
    @(posedge clk_50mhz);
    #1;
    reset_n_internal = 1'b1;
    dv_base = dv_cnt;
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    tb_active = 1'b0;
    repeat (3) step();
    chk("mrst_stale_dv", dv_cnt - dv_base, 0);
    chk("mrst_stale_busy", busy, 0);
    wr_en = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("mrst_lat1_dv", tx_dv, 0);
    chk("mrst_lat1_count", count, 1);
    step();
    chk("mrst_lat2_dv", tx_dv, 1);
    chk("mrst_lat2_byte", tx_byte, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
